sha256_multiblock: RTL and testbench

SHA256_MULTIBLOCK -- requirements
Module: sha256_multiblock

---
 rtl/sha256_pkg.sv | 29 ++
 rtl/sha256_round.sv | 41 ++++
 rtl/sha256_multiblock.sv | 188 ++++++++++++++++++
 tb/tb_sha256_multiblock.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the controller state type.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_COMPUTE,
    S_UPDATE,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  input  logic [31:0] h_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o,
  output logic [31:0] f_o,
  output logic [31:0] g_o,
  output logic [31:0] h_o
);

  logic [31:0] bsig0, bsig1, ch, maj, t1, t2;

  assign bsig0 = {a_i[1:0], a_i[31:2]} ^ {a_i[12:0], a_i[31:13]} ^ {a_i[21:0], a_i[31:22]};
  assign bsig1 = {e_i[5:0], e_i[31:6]} ^ {e_i[10:0], e_i[31:11]} ^ {e_i[24:0], e_i[31:25]};
  assign ch    = (e_i & f_i) ^ (~e_i & g_i);
  assign maj   = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
  assign t1    = h_i + bsig1 + ch + k_i + w_i;
  assign t2    = bsig0 + maj;

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_multiblock.sv
// Memory-mapped SHA-256 engine: reads a word message, pads on the fly, writes the 8-word digest.
//   state   | meaning
//   IDLE    | waiting for start, word 0 address presented on accept
//   PRIME   | second word address presented, round counter cleared
//   COMPUTE | 64 rounds, one per cycle
//   UPDATE  | fold working vars into h, next block or write-out
//   WRITE   | 8 digest words to output_addr..+7
//   DONE    | single-cycle done pulse
module sha256_multiblock
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [15:0] MAXW16 = 16'(MAX_WORDS);

  state_e            state_q;
  logic [5:0]        t_q;
  logic [12:0]       blk_left_q;
  logic              busy_q, done_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [15:0]       nw_q;
  logic [ADDR_W-1:0] out_addr_q, blk_addr_q;
  logic [16:0]       gbase_q;
  logic [31:0]       h_q [8];
  logic [31:0]       v_q [8];
  logic [31:0]       w_q [16];

  logic [15:0]       nw_clamp;
  logic [16:0]       nw_p2, nw17, g_idx;
  logic [12:0]       blocks_start;
  logic [6:0]        rd_idx;
  logic              rd_ok, nxt_ok, last_blk;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       w_pad, w_sched, w_cur, ssig0, ssig1;
  logic [31:0]       rnd [8];
  logic [31:0]       h_sum [8];

  assign nw_clamp     = (num_words > MAXW16) ? MAXW16 : num_words;
  assign nw_p2        = {1'b0, nw_clamp} + 17'd2;
  assign blocks_start = nw_p2[16:4] + 13'd1;

  assign nw17     = {1'b0, nw_q};
  assign g_idx    = gbase_q + {11'b0, t_q};
  assign last_blk = (blk_left_q == 13'd1);

  // Read pipeline runs two words ahead of the round that consumes them.
  assign rd_idx  = (state_q == S_PRIME) ? 7'd1 : ({1'b0, t_q} + 7'd2);
  assign rd_ok   = (rd_idx < 7'd16) && ((gbase_q + {10'b0, rd_idx}) < nw17);
  assign rd_addr = blk_addr_q + ADDR_W'(rd_idx);
  assign nxt_ok  = (gbase_q + 17'd16) < nw17;

  always_comb begin
    w_pad = 32'h0;
    if (g_idx < nw17)                 w_pad = mem_read_data;
    else if (g_idx == nw17)           w_pad = 32'h8000_0000;
    else if (last_blk && t_q == 6'd15) w_pad = {11'b0, nw_q, 5'b0};
  end

  assign ssig0   = {w_q[1][6:0], w_q[1][31:7]} ^ {w_q[1][17:0], w_q[1][31:18]} ^ (w_q[1] >> 3);
  assign ssig1   = {w_q[14][16:0], w_q[14][31:17]} ^ {w_q[14][18:0], w_q[14][31:19]} ^ (w_q[14] >> 10);
  assign w_sched = ssig1 + w_q[9] + ssig0 + w_q[0];
  assign w_cur   = (t_q < 6'd16) ? w_pad : w_sched;

  sha256_round u_round (
    .a_i(v_q[0]), .b_i(v_q[1]), .c_i(v_q[2]), .d_i(v_q[3]),
    .e_i(v_q[4]), .f_i(v_q[5]), .g_i(v_q[6]), .h_i(v_q[7]),
    .w_i(w_cur),  .k_i(K[t_q]),
    .a_o(rnd[0]), .b_o(rnd[1]), .c_o(rnd[2]), .d_o(rnd[3]),
    .e_o(rnd[4]), .f_o(rnd[5]), .g_o(rnd[6]), .h_o(rnd[7])
  );

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        nw_q       <= nw_clamp;
        out_addr_q <= output_addr;
        blk_addr_q <= message_addr;
        gbase_q    <= '0;
        h_q        <= IV;
        v_q        <= IV;
      end
      S_COMPUTE: begin
        v_q <= rnd;
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_cur;
      end
      S_UPDATE: begin
        h_q        <= h_sum;
        v_q        <= h_sum;
        blk_addr_q <= blk_addr_q + ADDR_W'(16);
        gbase_q    <= gbase_q + 17'd16;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      blk_left_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_PRIME;
          busy_q     <= 1'b1;
          blk_left_q <= blocks_start;
          if (nw_clamp != 16'd0) addr_q <= message_addr;
        end
        S_PRIME: begin
          state_q <= S_COMPUTE;
          t_q     <= '0;
          if (rd_ok) addr_q <= rd_addr;
        end
        S_COMPUTE: begin
          t_q <= t_q + 6'd1;
          if (rd_ok) addr_q <= rd_addr;
          if (t_q == 6'd63) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          blk_left_q <= blk_left_q - 13'd1;
          if (last_blk) begin
            state_q <= S_WRITE;
            t_q     <= '0;
            we_q    <= 1'b1;
            addr_q  <= out_addr_q;
            wdata_q <= h_sum[0];
          end else begin
            state_q <= S_PRIME;
            if (nxt_ok) addr_q <= blk_addr_q + ADDR_W'(16);
          end
        end
        S_WRITE: begin
          if (t_q == 6'd7) begin
            state_q <= S_DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            t_q     <= t_q + 6'd1;
            addr_q  <= addr_q + ADDR_W'(1);
            wdata_q <= h_q[t_q[2:0] + 3'd1];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_clk        = clk;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_sha256_multiblock.sv
// Self-checking bench: random messages hashed by a queue-based SHA-256 model and compared to memory writes.
module tb_sha256_multiblock;

  localparam int MAXW = 64;

  localparam logic [31:0] RK [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DG_ABCD  = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [15:0] num_words = '0, message_addr = '0, output_addr = '0;
  logic        busy, done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] mem [0:65535];
  logic [31:0] msg_w [0:127];
  logic [15:0] wr_a [$];
  logic [31:0] wr_d [$];
  logic [15:0] rd_a [$];
  int n_pass = 0, n_tot = 0;

  sha256_multiblock #(.MAX_WORDS(MAXW), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .message_addr(message_addr), .output_addr(output_addr),
    .busy(busy), .done(done), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: build the padded message explicitly, then run textbook SHA-256 on it.
  function automatic void ref_sha(input int nw_raw, output logic [255:0] dg, output int nblk);
    logic [31:0] q [$];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    int nw;
    nw = (nw_raw > MAXW) ? MAXW : nw_raw;
    for (int i = 0; i < nw; i++) q.push_back(msg_w[i]);
    q.push_back(32'h8000_0000);
    while (q.size() % 16 != 14) q.push_back(32'h0);
    q.push_back(32'h0);
    q.push_back(32'(nw * 32));
    nblk = q.size() / 16;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nblk; blk++) begin
      for (int t = 0; t < 64; t++)
        if (t < 16) w[t] = q[16*blk + t];
        else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + RK[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    dg = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] written_digest();
    logic [255:0] r;
    r = 'x;
    if (wr_d.size() == 8)
      for (int k = 0; k < 8; k++) r[255-32*k -: 32] = wr_d[k];
    return r;
  endfunction

  task automatic fill_msg();
    for (int i = 0; i < 128; i++) msg_w[i] = $urandom;
  endtask

  // Start a hash and follow it to done; lat is the cycle (1 = cycle after the accept edge) with done high.
  task automatic run_hash(input int nw, input logic [15:0] ma, input logic [15:0] oa,
                          input int ign_cyc, output int lat);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    for (int i = 0; i < nw && i < 128; i++) mem[16'(ma + 16'(i))] = msg_w[i];
    @(negedge clk);
    start = 1'b1; num_words = 16'(nw); message_addr = ma; output_addr = oa;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_write_data);
        mem[mem_addr] = mem_write_data;
      end else if (!done && wr_a.size() == 0) rd_a.push_back(mem_addr);
      if (done) begin lat = c; break; end
      if (c == 1) begin
        start = 1'b0;
        num_words = 16'($urandom); message_addr = 16'($urandom); output_addr = 16'($urandom);
      end
      if (c == ign_cyc) start = 1'b1;
      if (c == ign_cyc + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_tot++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_tot++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else n_pass++;
    n_tot++; if (mem_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", mem_addr); else n_pass++;
    n_tot++; if (mem_write_data !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_write_data); else n_pass++;
  endtask

  task automatic test_empty();
    int lat; logic [255:0] dg; int nb; bit ok;
    run_hash(0, 16'h0200, 16'h0800, 0, lat);
    ref_sha(0, dg, nb);
    n_tot++; if (lat !== 75) $display("FAIL empty_latency got %0d want 75", lat); else n_pass++;
    n_tot++; if (written_digest() !== DG_EMPTY) $display("FAIL empty_digest got %h want %h", written_digest(), DG_EMPTY); else n_pass++;
    n_tot++; if (dg !== DG_EMPTY) $display("FAIL empty_model got %h want %h", dg, DG_EMPTY); else n_pass++;
    ok = (wr_a.size() == 8);
    for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] !== 16'(16'h0800 + 16'(k))) ok = 0;
    n_tot++; if (!ok) $display("FAIL empty_waddr got %0d writes want 8 at 0800..0807", wr_a.size()); else n_pass++;
  endtask

  task automatic test_abcd();
    int lat;
    msg_w[0] = 32'h61626364;
    run_hash(1, 16'h0300, 16'h0900, 0, lat);
    n_tot++; if (lat !== 75) $display("FAIL abcd_latency got %0d want 75", lat); else n_pass++;
    n_tot++; if (written_digest() !== DG_ABCD) $display("FAIL abcd_digest got %h want %h", written_digest(), DG_ABCD); else n_pass++;
  endtask

  task automatic test_boundary();
    int lat, nb; logic [255:0] dg;
    int nws [2] = '{13, 14};
    int lats [2] = '{75, 141};
    for (int i = 0; i < 2; i++) begin
      fill_msg();
      run_hash(nws[i], 16'h1000, 16'h2000, 0, lat);
      ref_sha(nws[i], dg, nb);
      n_tot++; if (lat !== lats[i]) $display("FAIL bound%0d_latency got %0d want %0d", nws[i], lat, lats[i]); else n_pass++;
      n_tot++; if (written_digest() !== dg) $display("FAIL bound%0d_digest got %h want %h", nws[i], written_digest(), dg); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int lat, nb; logic [255:0] dg; bit ok;
    fill_msg();
    run_hash(20, 16'h1000, 16'hFFFC, 0, lat);
    ref_sha(20, dg, nb);
    n_tot++; if (lat !== 66*nb + 9) $display("FAIL wrap_latency got %0d want %0d", lat, 66*nb + 9); else n_pass++;
    n_tot++; if (written_digest() !== dg) $display("FAIL wrap_digest got %h want %h", written_digest(), dg); else n_pass++;
    ok = (wr_a.size() == 8);
    for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] !== 16'(16'hFFFC + 16'(k))) ok = 0;
    n_tot++; if (!ok) $display("FAIL wrap_waddr got %0d writes first %h want FFFC..0003", wr_a.size(), wr_a.size() ? wr_a[0] : 16'hx); else n_pass++;
    ok = 1;
    for (int k = 0; k < rd_a.size(); k++) if (rd_a[k] < 16'h1000 || rd_a[k] > 16'h1013) ok = 0;
    n_tot++; if (!ok) $display("FAIL wrap_read_range got out-of-range address want 1000..1013"); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat, nb; logic [255:0] dg;
    fill_msg();
    run_hash(30, 16'h3000, 16'h4000, 30, lat);
    ref_sha(30, dg, nb);
    n_tot++; if (lat !== 66*nb + 9) $display("FAIL ignore_latency got %0d want %0d", lat, 66*nb + 9); else n_pass++;
    n_tot++; if (written_digest() !== dg) $display("FAIL ignore_digest got %h want %h", written_digest(), dg); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, nb, nwr, ndone; logic [255:0] dg;
    fill_msg();
    for (int i = 0; i < 30; i++) mem[16'(16'h5000 + 16'(i))] = msg_w[i];
    @(negedge clk);
    start = 1'b1; num_words = 16'd30; message_addr = 16'h5000; output_addr = 16'h6000;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tot++; if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0)
      $display("FAIL midreset_outputs got busy=%b we=%b addr=%h want 0/0/0000", busy, mem_we, mem_addr); else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nwr = 0; ndone = 0;
    repeat (200) begin
      @(negedge clk);
      if (mem_we) nwr++;
      if (done) ndone++;
    end
    n_tot++; if (nwr + ndone !== 0) $display("FAIL midreset_quiet got %0d writes %0d done want 0", nwr, ndone); else n_pass++;
    fill_msg();
    run_hash(9, 16'h5100, 16'h6100, 0, lat);
    ref_sha(9, dg, nb);
    n_tot++; if (written_digest() !== dg) $display("FAIL midreset_rehash got %h want %h", written_digest(), dg); else n_pass++;
  endtask

  task automatic test_random();
    int lat, nb, nw; logic [255:0] dg; logic [15:0] ma;
    for (int it = 0; it < 7; it++) begin
      fill_msg();
      nw = (it == 6) ? 100 : int'($urandom_range(0, MAXW));
      ma = 16'($urandom);
      run_hash(nw, ma, 16'($urandom), 0, lat);
      ref_sha(nw, dg, nb);
      n_tot++; if (lat !== 66*nb + 9) $display("FAIL rand%0d_latency nw=%0d got %0d want %0d", it, nw, lat, 66*nb + 9); else n_pass++;
      n_tot++; if (written_digest() !== dg) $display("FAIL rand%0d_digest nw=%0d got %h want %h", it, nw, written_digest(), dg); else n_pass++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_empty();
    test_abcd();
    test_boundary();
    test_wrap();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
